// File: rtl/alu_op_sequencer_if.sv
// Request and result handshake bundle between a producer/consumer and the ALU issue stage.
// The master side drives requests and accepts results; the slave side is the sequencer.
interface alu_op_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [3:0]  in_cmd;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [3:0]  res_cmd;

  modport master (
    output in_valid, in_a, in_b, in_cmd, res_ready,
    input  in_ready, res_valid, res_data, res_cmd
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cmd, res_ready,
    output in_ready, res_valid, res_data, res_cmd
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue stage for an 8-bit ALU: queues requests in a small FIFO, issues them one at a time,
// and holds each 16-bit result with its command until the consumer takes it.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [3:0]          alu_cmd,
  output logic                alu_en,
  input  logic [15:0]         alu_out,
  output logic [PTR_W:0]      count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t             state_reg;
  logic [7:0]         mem_a   [DEPTH];
  logic [7:0]         mem_b   [DEPTH];
  logic [3:0]         mem_cmd [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic [7:0]         alu_a_reg;
  logic [7:0]         alu_b_reg;
  logic [3:0]         alu_cmd_reg;
  logic               alu_en_reg;
  logic               res_valid_reg;
  logic [15:0]        res_data_reg;
  logic [3:0]         res_cmd_reg;

  logic has_entry;
  logic push;
  logic pop;

  // Readiness looks only at registered occupancy, never at a same-cycle pop.
  assign has_entry    = (count_reg != '0);
  assign bus.in_ready = !rst && (count_reg != FULL_COUNT);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = has_entry &&
                        ((state_reg == IDLE) || ((state_reg == HOLD) && bus.res_ready));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_reg]   <= bus.in_a;
      mem_b[wr_ptr_reg]   <= bus.in_b;
      mem_cmd[wr_ptr_reg] <= bus.in_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_cmd_reg   <= '0;
      alu_en_reg    <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_cmd_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        alu_a_reg   <= mem_a[rd_ptr_reg];
        alu_b_reg   <= mem_b[rd_ptr_reg];
        alu_cmd_reg <= mem_cmd[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      // The enable pulse is registered, so it is high exactly in the cycle spent in ISSUE.
      alu_en_reg <= pop;

      case (state_reg)
        IDLE: begin
          if (pop) begin
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          res_data_reg  <= alu_out;
          res_cmd_reg   <= alu_cmd_reg;
          res_valid_reg <= 1'b1;
          state_reg     <= HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
            state_reg     <= pop ? ISSUE : IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign alu_a         = alu_a_reg;
  assign alu_b         = alu_b_reg;
  assign alu_cmd       = alu_cmd_reg;
  assign alu_en        = alu_en_reg;
  assign count         = count_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_data  = res_data_reg;
  assign bus.res_cmd   = res_cmd_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed requests push expected results into a queue,
// a monitor pops and compares on every result handshake.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_cmd;
  logic        alu_en;
  logic [15:0] alu_out;
  logic [2:0]  count;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_cmd (alu_cmd),
    .alu_en  (alu_en),
    .alu_out (alu_out),
    .count   (count)
  );

  // Behavioural stand-in for the ALU: 0000 ADD, 0010 MUL, 1111 BUF(a); output zero when disabled.
  always_comb begin
    alu_out = 16'h0000;
    if (alu_en) begin
      case (alu_cmd)
        4'b0000: alu_out = {8'h00, alu_a} + {8'h00, alu_b};
        4'b0010: alu_out = {8'h00, alu_a} * {8'h00, alu_b};
        4'b1111: alu_out = {8'h00, alu_a};
        default: alu_out = 16'h0000;
      endcase
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [19:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    logic [19:0] e;
    if (!rst && bus.res_valid && bus.res_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_result: got cmd=%h data=%0d expected none", bus.res_cmd, bus.res_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.res_data !== e[15:0] || bus.res_cmd !== e[19:16]) begin
          fails++;
          $display("[TB] FAIL result: got cmd=%h data=%0d expected cmd=%h data=%0d",
                   bus.res_cmd, bus.res_data, e[19:16], e[15:0]);
        end else begin
          $display("[TB] result cmd=%h data=%0d ok", bus.res_cmd, bus.res_data);
        end
      end
    end
  end

  // Offer one request (called at posedge+1) and return at posedge+1 after it is accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c, input logic [15:0] r);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cmd   = c;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back({c, r});
        $display("[TB] request a=%0d b=%0d cmd=%h accepted", a, b, c);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    tests++;
    fails++;
    $display("[TB] FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.res_valid && count == 3'd0) begin
        check(name, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        return;
      end
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check(name, 32'(bus.res_valid), 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cmd    = '0;
    bus.res_ready = 1'b0;

    // 1. reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_count", 32'(count), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_alu_en", 32'(alu_en), 32'd0);
    check("reset_res_valid", 32'(bus.res_valid), 32'd0);
    check("reset_res_data", 32'(bus.res_data), 32'd0);
    @(posedge clk);
    #1;

    // 2. single ADD, latency
    bus.res_ready = 1'b1;
    send(8'd20, 8'd10, 4'b0000, 16'd30);
    @(negedge clk);
    check("lat_en_n0", 32'(alu_en), 32'd0);
    @(negedge clk);
    check("lat_en_n1", 32'(alu_en), 32'd1);
    @(negedge clk);
    check("lat_en_n2", 32'(alu_en), 32'd0);
    check("lat_valid_n2", 32'(bus.res_valid), 32'd1);
    check("lat_data_n2", 32'(bus.res_data), 32'd30);
    check("lat_cmd_n2", 32'(bus.res_cmd), 32'd0);
    @(posedge clk);
    #1;
    wait_drain("drain_single");

    // 3. fill the FIFO with the consumer stalled
    bus.res_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 8'd1, 4'b0000, 16'(i + 1));
    end
    @(negedge clk);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    fork
      send(8'd6, 8'd1, 4'b0000, 16'd7);
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
      end
    join
    wait_drain("drain_full");

    // 4. result held while consumer stalls, with another entry waiting
    bus.res_ready = 1'b0;
    send(8'd25, 8'd17, 4'b0000, 16'd42);
    send(8'd3, 8'd4, 4'b0000, 16'd7);
    wait_valid("hold_wait_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.res_valid), 32'd1);
      check("hold_data", 32'(bus.res_data), 32'd42);
      check("hold_no_en", 32'(alu_en), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    wait_drain("drain_hold");

    // 5. simultaneous push and pop at count=2, mixed commands
    bus.res_ready = 1'b0;
    send(8'd7, 8'd8, 4'b0000, 16'd15);
    send(8'd9, 8'd5, 4'b1111, 16'd9);
    send(8'd12, 8'd11, 4'b0010, 16'd132);
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'd100;
    bus.in_b      = 8'd200;
    bus.in_cmd    = 4'b0000;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("pp_count_before", 32'(count), 32'd2);
    check("pp_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back({4'b0000, 16'd300});
    $display("[TB] request a=100 b=200 cmd=0 accepted with pop");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("pp_count_after", 32'(count), 32'd2);
    @(posedge clk);
    #1;
    wait_drain("drain_pushpop");

    // 6. reset in HOLD with three queued
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'(10 + i), 8'd1, 4'b0000, 16'(11 + i));
    end
    wait_valid("rst_wait_valid");
    @(negedge clk);
    check("rst_pre_count", 32'(count), 32'd3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_no_en", 32'(alu_en), 32'd0);
      check("rst_no_valid", 32'(bus.res_valid), 32'd0);
    end
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
